elbeth_branch_predictor: RTL and testbench

- Parametrised branch target buffer (BTB) with 2-bit saturating direction counters.
- IF stage: combinational lookup on the fetch PC returns a predicted next PC.
- ID stage: the resolved branch/jump outcome from the branch unit trains the table and raises a same-cycle mispredict with the redirect PC.
- Direct-mapped, ENTRIES deep, XLEN wide; successor to the purely combinational resolve-only branch unit.

---
 rtl/elbeth_branch_predictor.sv | 140 ++++++++++++++
 tb/tb_elbeth_branch_predictor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup on the fetch PC is combinational. Resolved control-flow outcomes from
// ID train the table on the rising edge and raise a same-cycle mispredict.
// Optional statistics counters are enabled by defining ELBETH_BP_STATS_EN.
module elbeth_branch_predictor #(
  parameter int          XLEN     = 32,
  parameter int          ENTRIES  = 16,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef ELBETH_BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] jmp_q, jmp_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [1:0]         cnt_q [ENTRIES];
  logic [1:0]         cnt_d [ENTRIES];

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             upd_hit;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Fetch-side lookup reads the pre-update table contents
  always_comb begin
    pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = pred_hit && (jmp_q[if_idx] || cnt_q[if_idx][1]);
    pred_target = pred_taken ? target_q[if_idx] : if_pc + PC_STEP;
  end

  // Resolve-side mispredict detection and redirect address
  always_comb begin
    mispredict  = rst_n && upd_valid &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + PC_STEP;
  end

  // Training: update a hitting entry, or allocate on a taken miss
  always_comb begin
    valid_d  = valid_q;
    jmp_d    = jmp_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          cnt_d[upd_idx]    = (cnt_q[upd_idx] == 2'b11) ? 2'b11 : cnt_q[upd_idx] + 2'b01;
          target_d[upd_idx] = upd_target;
        end else begin
          cnt_d[upd_idx] = (cnt_q[upd_idx] == 2'b00) ? 2'b00 : cnt_q[upd_idx] - 2'b01;
        end
        jmp_d[upd_idx] = upd_is_jump;
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        jmp_d[upd_idx]    = upd_is_jump;
        cnt_d[upd_idx]    = upd_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  // Table state register; reset invalidates all entries and reloads counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      jmp_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_INIT;
      end
    end else begin
      valid_q  <= valid_d;
      jmp_q    <= jmp_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ELBETH_BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Wrapping event counters for resolved branches and mispredicts
  always_comb begin
    stat_branches_d    = stat_branches_q + {31'd0, upd_valid};
    stat_mispredicts_d = stat_mispredicts_q + {31'd0, mispredict};
  end

  // Statistics register, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_elbeth_branch_predictor.sv
// Testbench for elbeth_branch_predictor: directed scenarios plus randomized
// traffic, checked against a behavioural model of the BTB.
module tb_elbeth_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef ELBETH_BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: word address split into set number and quotient
  bit          m_valid [16];
  int unsigned m_key   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  bit          m_jmp   [16];
  logic [31:0] m_sb, m_sm;

  elbeth_branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef ELBETH_BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_key[i] = 0; m_tgt[i] = '0; m_cnt[i] = 1; m_jmp[i] = 0;
    end
    m_sb = '0; m_sm = '0;
  endtask

  task automatic modelPredict(input logic [31:0] pc, output bit hit, output bit tk,
                              output logic [31:0] tg);
    int unsigned word;
    int unsigned set;
    word = pc / 4;
    set  = word % 16;
    hit  = m_valid[set] && (m_key[set] == word / 16);
    tk   = hit && (m_jmp[set] || m_cnt[set] >= 2);
    tg   = tk ? m_tgt[set] : pc + 32'd4;
  endtask

  task automatic applyStimulus(input logic rst, input logic [31:0] fpc, input logic uv,
                               input logic [31:0] upc, input logic uj, input logic ut,
                               input logic [31:0] utg, input logic upt, input logic [31:0] uptg);
    rst_n = rst; if_pc = fpc; upd_valid = uv; upd_pc = upc; upd_is_jump = uj;
    upd_taken = ut; upd_target = utg; upd_pred_taken = upt; upd_pred_target = uptg;
  endtask

  // one full cycle: drive, compare against model, then advance the model
  task automatic runCycle(input logic rst, input logic [31:0] fpc, input logic uv,
                          input logic [31:0] upc, input logic uj, input logic ut,
                          input logic [31:0] utg, input logic upt, input logic [31:0] uptg);
    bit eh, et, em, uh;
    logic [31:0] etg;
    int unsigned word, set;
    @(negedge clk);
    applyStimulus(rst, fpc, uv, upc, uj, ut, utg, upt, uptg);
    #1;
    modelPredict(fpc, eh, et, etg);
    em = rst && uv && ((ut != upt) || (ut && utg != uptg));
    checkOutput("pred_hit", {63'd0, pred_hit}, {63'd0, eh});
    checkOutput("pred_taken", {63'd0, pred_taken}, {63'd0, et});
    checkOutput("pred_target", {32'd0, pred_target}, {32'd0, etg});
    checkOutput("mispredict", {63'd0, mispredict}, {63'd0, em});
    if (em) checkOutput("redirect_pc", {32'd0, redirect_pc}, {32'd0, ut ? utg : upc + 32'd4});
`ifdef ELBETH_BP_STATS_EN
    checkOutput("stat_branches", {32'd0, stat_branches}, {32'd0, m_sb});
    checkOutput("stat_mispredicts", {32'd0, stat_mispredicts}, {32'd0, m_sm});
`endif
    if (!rst) begin
      modelReset();
    end else if (uv) begin
      m_sb = m_sb + 1;
      if (em) m_sm = m_sm + 1;
      word = upc / 4;
      set  = word % 16;
      uh   = m_valid[set] && (m_key[set] == word / 16);
      if (uh) begin
        m_cnt[set] = ut ? ((m_cnt[set] + 1 > 3) ? 3 : m_cnt[set] + 1)
                        : ((m_cnt[set] - 1 < 0) ? 0 : m_cnt[set] - 1);
        m_jmp[set] = uj;
        if (ut) m_tgt[set] = utg;
      end else if (ut) begin
        m_valid[set] = 1; m_key[set] = word / 16; m_tgt[set] = utg;
        m_jmp[set] = uj; m_cnt[set] = uj ? 3 : 2;
      end
    end
  endtask

  task automatic idle(input logic [31:0] fpc);
    runCycle(1'b1, fpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // resolve a branch whose carried prediction comes from the model
  task automatic resolve(input logic [31:0] fpc, input logic [31:0] upc, input logic uj,
                         input logic ut, input logic [31:0] utg);
    bit h, t;
    logic [31:0] g;
    modelPredict(upc, h, t, g);
    runCycle(1'b1, fpc, 1'b1, upc, uj, ut, utg, t, g);
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    modelReset();

    // reset with a pending update: no mispredict, no allocation
    runCycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    checkOutput("rst_pred_target", {32'd0, pred_target}, 64'h104);
    checkOutput("rst_mispredict", {63'd0, mispredict}, 64'd0);
    idle(32'h100);
    checkOutput("rst_no_alloc", {63'd0, pred_hit}, 64'd0);

    // first BEQ resolution, lookup same cycle still misses
    runCycle(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    checkOutput("beq_mispredict", {63'd0, mispredict}, 64'd1);
    checkOutput("beq_redirect", {32'd0, redirect_pc}, 64'h80);
    checkOutput("same_cycle_miss", {63'd0, pred_hit}, 64'd0);
    idle(32'h100);
    checkOutput("beq_hit_taken", {62'd0, pred_hit, pred_taken}, 64'd3);
    checkOutput("beq_target", {32'd0, pred_target}, 64'h80);

    // saturation at 0x200
    repeat (3) resolve(32'h200, 32'h200, 1'b0, 1'b1, 32'h240);
    resolve(32'h200, 32'h200, 1'b0, 1'b0, 32'h0);
    idle(32'h200);
    checkOutput("sat_still_taken", {63'd0, pred_taken}, 64'd1);
    resolve(32'h200, 32'h200, 1'b0, 1'b0, 32'h0);
    idle(32'h200);
    checkOutput("sat_not_taken", {63'd0, pred_taken}, 64'd0);
    checkOutput("sat_fallthrough", {32'd0, pred_target}, 64'h204);
    resolve(32'h200, 32'h200, 1'b0, 1'b0, 32'h0);
    checkOutput("nt_no_mispredict", {63'd0, mispredict}, 64'd0);

    // alias replacement and JALR target correction
    resolve(32'h40, 32'h40, 1'b1, 1'b1, 32'h1000);
    resolve(32'h40, 32'h80, 1'b0, 1'b1, 32'h2000);
    idle(32'h40);
    checkOutput("alias_miss", {63'd0, pred_hit}, 64'd0);
    resolve(32'h300, 32'h300, 1'b1, 1'b1, 32'h500);
    runCycle(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b1, 32'h600, 1'b1, 32'h500);
    checkOutput("jalr_mispredict", {63'd0, mispredict}, 64'd1);
    checkOutput("jalr_redirect", {32'd0, redirect_pc}, 64'h600);
    idle(32'h300);
    checkOutput("jalr_new_target", {32'd0, pred_target}, 64'h600);

`ifdef ELBETH_BP_STATS_EN
    runCycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    runCycle(1'b1, 32'h0, 1'b1, 32'h400, 1'b0, 1'b1, 32'h480, 1'b0, 32'h404);
    runCycle(1'b1, 32'h0, 1'b1, 32'h400, 1'b0, 1'b1, 32'h480, 1'b1, 32'h480);
    runCycle(1'b1, 32'h0, 1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 1'b0, 32'h408);
    runCycle(1'b1, 32'h0, 1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 1'b0, 32'h408);
    runCycle(1'b1, 32'h0, 1'b1, 32'h408, 1'b0, 1'b1, 32'h900, 1'b0, 32'h40c);
    idle(32'h0);
    checkOutput("stat_five", {32'd0, stat_branches}, 64'd5);
    checkOutput("stat_two", {32'd0, stat_mispredicts}, 64'd2);
    force dut.stat_branches_q = 32'hFFFF_FFFF;
    force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_branches_q;
    release dut.stat_mispredicts_q;
    m_sb = 32'hFFFF_FFFF; m_sm = 32'hFFFF_FFFF;
    runCycle(1'b1, 32'h0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 1'b0, 32'h14);
    idle(32'h0);
    checkOutput("stat_wrap_b", {32'd0, stat_branches}, 64'd0);
    checkOutput("stat_wrap_m", {32'd0, stat_mispredicts}, 64'd0);
`endif

    // randomized traffic over a small PC pool to force aliasing
    for (int n = 0; n < 400; n++) begin
      logic [31:0] fpc, upc, utg;
      bit h, t;
      logic [31:0] g;
      fpc = 32'($urandom_range(0, 127)) * 4;
      upc = 32'($urandom_range(0, 127)) * 4;
      utg = 32'($urandom_range(0, 1023)) * 4;
      modelPredict(upc, h, t, g);
      if ($urandom_range(0, 4) == 0) begin
        t = 1'($urandom_range(0, 1));
        g = 32'($urandom_range(0, 1023)) * 4;
      end
      runCycle(($urandom_range(0, 59) != 0), fpc, 1'($urandom_range(0, 3) != 0), upc,
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), utg, t, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
